// File: rtl/instr_fetch_rv32i.sv
// RV32I instruction fetch stage: PC register, single-entry fetch buffer with
// valid/ready handshake, redirect flush, EBREAK halt and accepted-fetch counter.
module instr_fetch_rv32i #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter bit          HALT_ON_EBREAK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ADDR,
    input  logic [31:0] INSTR,
    output logic        IF_VALID,
    input  logic        IF_READY,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    input  logic        REDIR_EN,
    input  logic [31:0] REDIR_PC,
    output logic        MISALIGN,
    output logic        HALTED,
    output logic [31:0] FETCH_CNT
);

    localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'd3;
    localparam logic [31:0] EBREAK     = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        misalign_q, misalign_d;
    logic        halted_q, halted_d;
    logic [31:0] cnt_q, cnt_d;
    logic        accept;
    logic        load;

    assign accept = valid_q && IF_READY;
    assign load   = (state_q == ST_RUN) && (!valid_q || IF_READY);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ifpc_d     = ifpc_q;
        misalign_d = misalign_q;
        // An accept in the redirect cycle is still a completed handshake.
        cnt_d      = cnt_q + {31'd0, accept};

        if (REDIR_EN) begin
            pc_d    = REDIR_PC & ~32'd3;
            valid_d = 1'b0;
            state_d = ST_RUN;
            if (REDIR_PC[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            if (state_q == ST_BOOT) begin
                state_d = ST_RUN;
            end
            if (load) begin
                instr_d = INSTR;
                ifpc_d  = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
                if (HALT_ON_EBREAK && (INSTR == EBREAK)) begin
                    state_d = ST_HALT;
                end
            end else if (accept) begin
                valid_d = 1'b0;
            end
        end

        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_ADDR;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            ifpc_q     <= 32'd0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ifpc_q     <= ifpc_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ADDR      = pc_q;
    assign IF_VALID  = valid_q;
    assign IF_INSTR  = instr_q;
    assign IF_PC     = ifpc_q;
    assign MISALIGN  = misalign_q;
    assign HALTED    = halted_q;
    assign FETCH_CNT = cnt_q;

endmodule

// File: tb/tb_instr_fetch_rv32i.sv
// Directed bench for instr_fetch_rv32i: sequential fetch, back-pressure, redirect
// flush, misaligned redirect, EBREAK halt, PC wrap and mid-stream reset.
module tb_instr_fetch_rv32i;

    logic        clock;
    logic        reset;
    logic [31:0] ADDR;
    logic [31:0] INSTR;
    logic        IF_VALID;
    logic        IF_READY;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        REDIR_EN;
    logic [31:0] REDIR_PC;
    logic        MISALIGN;
    logic        HALTED;
    logic [31:0] FETCH_CNT;
    logic        ebrk_en;

    int vectors;
    int miscompares;

    instr_fetch_rv32i #(
        .RESET_PC      (32'h0000_0000),
        .HALT_ON_EBREAK(1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ADDR     (ADDR),
        .INSTR    (INSTR),
        .IF_VALID (IF_VALID),
        .IF_READY (IF_READY),
        .IF_INSTR (IF_INSTR),
        .IF_PC    (IF_PC),
        .REDIR_EN (REDIR_EN),
        .REDIR_PC (REDIR_PC),
        .MISALIGN (MISALIGN),
        .HALTED   (HALTED),
        .FETCH_CNT(FETCH_CNT)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM: each word is 0x1300_0000 | address; address 12 holds EBREAK when enabled.
    always_comb begin
        if (ebrk_en && (ADDR == 32'd12)) INSTR = 32'h0010_0073;
        else                             INSTR = 32'h1300_0000 | ADDR;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1300_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_checked();
        reset = 1'b1;
        tick();
        REDIR_EN = 1'b0;
        chk("rst_addr", ADDR, 32'h0);
        chk("rst_valid", {31'd0, IF_VALID}, 32'd0);
        chk("rst_instr", IF_INSTR, 32'h0);
        chk("rst_ifpc", IF_PC, 32'h0);
        chk("rst_misalign", {31'd0, MISALIGN}, 32'd0);
        chk("rst_halted", {31'd0, HALTED}, 32'd0);
        chk("rst_cnt", FETCH_CNT, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("boot_valid", {31'd0, IF_VALID}, 32'd0);
        chk("boot_addr", ADDR, 32'h0);
    endtask

    task automatic chk_payload(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] addr, input logic [31:0] cnt);
        chk({tag, "_valid"}, {31'd0, IF_VALID}, 32'd1);
        chk({tag, "_ifpc"}, IF_PC, pc);
        chk({tag, "_instr"}, IF_INSTR, instr);
        chk({tag, "_addr"}, ADDR, addr);
        chk({tag, "_cnt"}, FETCH_CNT, cnt);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        IF_READY    = 1'b1;
        REDIR_EN    = 1'b0;
        REDIR_PC    = 32'h0;
        ebrk_en     = 1'b0;

        // Sequential fetch of 0..28 with downstream always ready.
        reset_checked();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_payload("seq", 32'(4 * i), word_at(32'(4 * i)), 32'(4 * i + 4), 32'(i));
        end
        tick();
        chk("seq_cnt8", FETCH_CNT, 32'd8);
        chk("seq_ifpc32", IF_PC, 32'd32);

        // Back-pressure held at IF_PC=8, reset applied mid-stream.
        reset_checked();
        tick();
        tick();
        tick();
        chk_payload("bp_pre", 32'd8, 32'h1300_0008, 32'd12, 32'd2);
        IF_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_payload("bp_hold", 32'd8, 32'h1300_0008, 32'd12, 32'd2);
        end
        IF_READY = 1'b1;
        tick();
        chk_payload("bp_rel", 32'd12, 32'h1300_000C, 32'd16, 32'd3);

        // Redirect flushes an unaccepted payload without counting it.
        IF_READY = 1'b0;
        tick();
        REDIR_EN = 1'b1;
        REDIR_PC = 32'h40;
        tick();
        chk("flush_valid", {31'd0, IF_VALID}, 32'd0);
        chk("flush_addr", ADDR, 32'h40);
        chk("flush_cnt", FETCH_CNT, 32'd3);
        REDIR_EN = 1'b0;
        IF_READY = 1'b1;
        tick();
        chk_payload("redir40", 32'h40, 32'h1300_0040, 32'h44, 32'd3);

        // Misaligned redirect with a same-cycle accept.
        REDIR_EN = 1'b1;
        REDIR_PC = 32'h22;
        tick();
        chk("mis_addr", ADDR, 32'h20);
        chk("mis_flag", {31'd0, MISALIGN}, 32'd1);
        chk("mis_cnt", FETCH_CNT, 32'd4);
        chk("mis_valid", {31'd0, IF_VALID}, 32'd0);
        REDIR_EN = 1'b0;
        tick();
        chk_payload("mis_fetch", 32'h20, 32'h1300_0020, 32'h24, 32'd4);
        REDIR_EN = 1'b1;
        REDIR_PC = 32'h8;
        tick();
        chk("mis_sticky", {31'd0, MISALIGN}, 32'd1);
        chk("redir8_addr", ADDR, 32'h8);
        chk("redir8_cnt", FETCH_CNT, 32'd5);

        // EBREAK at address 12 halts with ADDR frozen at 16.
        REDIR_EN = 1'b0;
        ebrk_en  = 1'b1;
        tick();
        chk_payload("eb_pre", 32'd8, 32'h1300_0008, 32'd12, 32'd5);
        tick();
        chk_payload("eb_pay", 32'd12, 32'h0010_0073, 32'd16, 32'd6);
        chk("eb_halted", {31'd0, HALTED}, 32'd1);
        IF_READY = 1'b0;
        tick();
        chk_payload("eb_hold", 32'd12, 32'h0010_0073, 32'd16, 32'd6);
        IF_READY = 1'b1;
        tick();
        chk("eb_acc_valid", {31'd0, IF_VALID}, 32'd0);
        chk("eb_acc_cnt", FETCH_CNT, 32'd7);
        tick();
        chk("eb_frz_addr", ADDR, 32'd16);
        chk("eb_frz_valid", {31'd0, IF_VALID}, 32'd0);
        chk("eb_frz_halted", {31'd0, HALTED}, 32'd1);
        REDIR_EN = 1'b1;
        REDIR_PC = 32'h0;
        tick();
        chk("eb_exit_halted", {31'd0, HALTED}, 32'd0);
        chk("eb_exit_addr", ADDR, 32'h0);
        REDIR_EN = 1'b0;
        ebrk_en  = 1'b0;
        tick();
        chk_payload("eb_resume", 32'h0, 32'h1300_0000, 32'h4, 32'd7);

        // PC wrap at the top of the address space.
        REDIR_EN = 1'b1;
        REDIR_PC = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr", ADDR, 32'hFFFF_FFFC);
        chk("wrap_cnt", FETCH_CNT, 32'd8);
        REDIR_EN = 1'b0;
        tick();
        chk_payload("wrap_top", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'd8);
        tick();
        chk_payload("wrap_zero", 32'h0, 32'h1300_0000, 32'h4, 32'd9);

        // Reset overrides a simultaneous redirect and clears the sticky flag.
        REDIR_EN = 1'b1;
        REDIR_PC = 32'h40;
        reset_checked();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_rv32i.md
INSTR_FETCH_RV32I -- requirements
Module: instr_fetch_rv32i

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the program counter value loaded on reset (bits [1:0] are treated as 0).
REQ-002 The block SHALL have parameter HALT_ON_EBREAK, default 1, which when 1 makes a fetched EBREAK (32'h0010_0073) stop fetching.
REQ-003 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port ADDR, output, 32 bits: byte address to the instruction ROM; SHALL equal the PC register, with no added logic.
REQ-006 Port INSTR, input, 32 bits: ROM read data, combinational from ADDR within the same cycle.
REQ-007 Port IF_VALID, output, 1 bit: IF_INSTR and IF_PC hold a valid fetched instruction.
REQ-008 Port IF_READY, input, 1 bit: downstream accepts the IF_* payload this cycle.
REQ-009 Port IF_INSTR, output, 32 bits: the fetched instruction word.
REQ-010 Port IF_PC, output, 32 bits: the address IF_INSTR was fetched from.
REQ-011 Port REDIR_EN, input, 1 bit: branch/jump redirect request.
REQ-012 Port REDIR_PC, input, 32 bits: redirect target address.
REQ-013 Port MISALIGN, output, 1 bit: sticky flag, set when a redirect target has bits [1:0] != 0.
REQ-014 Port HALTED, output, 1 bit: high while the FSM is in HALT.
REQ-015 Port FETCH_CNT, output, 32 bits: count of payloads accepted downstream (IF_VALID && IF_READY).

Function
REQ-016 The FSM SHALL have three states: BOOT, RUN and HALT.
REQ-017 BOOT SHALL last exactly one cycle after reset deasserts, with no capture, and SHALL then go to RUN.
REQ-018 In RUN, a load condition exists when (!IF_VALID || IF_READY); on a load the block SHALL set IF_INSTR<=INSTR, IF_PC<=PC, IF_VALID<=1 and PC<=PC+4.
REQ-019 In RUN without a load condition, PC, IF_INSTR, IF_PC and IF_VALID SHALL all hold, so the payload stays stable under back-pressure.
REQ-020 In any state, when IF_VALID && IF_READY and no new load occurs, IF_VALID SHALL clear at the next edge.
REQ-021 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag raised.
REQ-022 REDIR_EN SHALL take priority over loads in every state: PC<=REDIR_PC & ~3, IF_VALID<=0 (flush, including any unaccepted payload), and the FSM SHALL go to RUN.
REQ-023 The first instruction from a redirect target SHALL appear with IF_VALID=1 one edge after the redirect edge (1-cycle redirect penalty).
REQ-024 If REDIR_PC[1:0] != 0 during a redirect, MISALIGN SHALL be set to 1 and SHALL stay at 1 until reset; the redirect itself still proceeds using the aligned address.
REQ-025 When HALT_ON_EBREAK=1 and a load captures INSTR==32'h0010_0073, the EBREAK payload SHALL still be presented, and the FSM SHALL go to HALT with PC frozen at EBREAK address+4.
REQ-026 In HALT no new loads SHALL occur; the pending payload SHALL still complete its handshake; the only exits are REDIR_EN or reset.
REQ-027 HALTED SHALL be 1 exactly while the state is HALT.
REQ-028 FETCH_CNT SHALL increment by 1 on each edge with IF_VALID && IF_READY, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 When redirect and accept occur in the same cycle, the accept SHALL still be counted.

Reset
REQ-030 When reset=1 at a rising edge: PC<=RESET_PC & ~3, IF_VALID<=0, IF_INSTR<=0, IF_PC<=0, MISALIGN<=0, FETCH_CNT<=0, state<=BOOT, HALTED=0.
REQ-031 Reset SHALL override REDIR_EN and any in-flight handshake, including reset asserted mid-stream or in HALT.
REQ-032 While reset=1, ADDR SHALL equal RESET_PC & ~3 from the first reset edge onward.

Verification
REQ-033 Reset released with IF_READY=1 and ROM holding distinct words at 0,4,...,28 -> ADDR steps 0,4,8,...,28 one per cycle after BOOT; IF_PC/IF_INSTR match word for word; FETCH_CNT=8 after 8 accepts.
REQ-034 IF_READY=0 for 3 cycles while IF_VALID=1 at IF_PC=8 -> IF_PC=8, IF_INSTR and ADDR=12 all stable; IF_READY=1 -> next payload IF_PC=12; no skipped or duplicated instruction.
REQ-035 REDIR_EN=1 with REDIR_PC=32'h40 while a payload is unaccepted -> IF_VALID=0 next cycle, then IF_PC=32'h40; FETCH_CNT is not incremented for the flushed payload.
REQ-036 REDIR_PC=32'h22 -> ADDR=32'h20 and MISALIGN=1; MISALIGN stays 1 through later redirects; it clears only on reset.
REQ-037 EBREAK at address 12 -> payload IF_PC=12 presented, HALTED=1, ADDR frozen at 16; redirect to 0 -> HALTED=0 and fetch resumes at 0.
REQ-038 Redirect to 32'hFFFF_FFFC -> next ADDR=0 (wrap); assert reset mid-stream -> all outputs match REQ-030 values at the next edge.
